// File: rtl/board_select_ctrl.sv
// ============================================================================
// board_select_ctrl : cursor / pair-selection controller for a 6x6 card board
// Revision: 1.0
// ============================================================================
`default_nettype none

module board_select_ctrl #(
  parameter int ID_W      = 4,
  parameter int MISS_HOLD = 50
) (
  input  logic            clk100_in,
  input  logic            rst_in,
  input  logic            btn_up_in,
  input  logic            btn_down_in,
  input  logic            btn_left_in,
  input  logic            btn_right_in,
  input  logic            btn_sel_in,
  input  logic            tick100_in,
  input  logic [ID_W-1:0] card_id_in,
  output logic [5:0]      card_addr_out,
  output logic [35:0]     hidden_bus,
  output logic [35:0]     blink_bus,
  output logic [35:0]     sel_bus,
  output logic [5:0]      cursor_out,
  output logic [4:0]      pairs_left_out,
  output logic            match_out,
  output logic            done_out
);

  localparam int CNT_W = (MISS_HOLD > 0) ? $clog2(MISS_HOLD + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ONE     = 3'd1,
    S_FETCH_A = 3'd2,
    S_FETCH_B = 3'd3,
    S_CMP     = 3'd4,
    S_MISS    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        cursor_q, cursor_d;
  logic [35:0]       hidden_q, hidden_d;
  logic [35:0]       sel_q, sel_d;
  logic [35:0]       blink_q, blink_d;
  logic [4:0]        pairs_q, pairs_d;
  logic [5:0]        addr_q, addr_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        a_q, a_d;
  logic [5:0]        b_q, b_d;
  logic [ID_W-1:0]   id_a_q, id_a_d;

  logic [2:0]        w_col;
  logic [5:0]        w_up, w_down, w_left, w_right, w_move;
  logic [4:0]        w_pairs_dec;

  // Wrapping cursor moves in row-major index space
  always_comb begin
    w_col   = 3'(cursor_q % 6'd6);
    w_up    = (cursor_q < 6'd6)   ? cursor_q + 6'd30 : cursor_q - 6'd6;
    w_down  = (cursor_q >= 6'd30) ? cursor_q - 6'd30 : cursor_q + 6'd6;
    w_left  = (w_col == 3'd0)     ? cursor_q + 6'd5  : cursor_q - 6'd1;
    w_right = (w_col == 3'd5)     ? cursor_q - 6'd5  : cursor_q + 6'd1;
    if (btn_up_in)         w_move = w_up;
    else if (btn_down_in)  w_move = w_down;
    else if (btn_left_in)  w_move = w_left;
    else if (btn_right_in) w_move = w_right;
    else                   w_move = cursor_q;
    w_pairs_dec = (pairs_q != 5'd0) ? pairs_q - 5'd1 : 5'd0;
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    hidden_d = hidden_q;
    sel_d    = sel_q;
    pairs_d  = pairs_q;
    match_d  = 1'b0;
    done_d   = done_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    id_a_d   = id_a_q;

    case (state_q)
      S_IDLE: begin
        if (btn_sel_in) begin
          if (!hidden_q[cursor_q]) begin
            a_d             = cursor_q;
            sel_d[cursor_q] = 1'b1;
            state_d         = S_ONE;
          end
        end else begin
          cursor_d = w_move;
        end
      end
      S_ONE: begin
        if (btn_sel_in) begin
          if (cursor_q == a_q) begin
            sel_d[a_q] = 1'b0;
            state_d    = S_IDLE;
          end else if (!hidden_q[cursor_q]) begin
            b_d             = cursor_q;
            sel_d[cursor_q] = 1'b1;
            state_d         = S_FETCH_A;
          end
        end else begin
          cursor_d = w_move;
        end
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: begin
        id_a_d  = card_id_in;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (id_a_q == card_id_in) begin
          hidden_d[a_q] = 1'b1;
          hidden_d[b_q] = 1'b1;
          sel_d         = '0;
          pairs_d       = w_pairs_dec;
          match_d       = 1'b1;
          state_d       = (w_pairs_dec == 5'd0) ? S_DONE : S_IDLE;
        end else begin
          cnt_d   = CNT_W'(MISS_HOLD);
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        if (tick100_in) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            sel_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      hidden_d = '1;
      sel_d    = '0;
      done_d   = 1'b1;
      blink_d  = '0;
    end else begin
      blink_d = 36'd1 << cursor_d;
    end

    // The address follows the state being entered so the table data lines up
    case (state_d)
      S_IDLE, S_ONE: addr_d = cursor_d;
      S_FETCH_A:     addr_d = a_d;
      S_FETCH_B:     addr_d = b_d;
      default:       addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk100_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cursor_q <= 6'd0;
      hidden_q <= '0;
      sel_q    <= '0;
      blink_q  <= 36'h1;
      pairs_q  <= 5'd18;
      addr_q   <= 6'd0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= 6'd0;
      b_q      <= 6'd0;
      id_a_q   <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      hidden_q <= hidden_d;
      sel_q    <= sel_d;
      blink_q  <= blink_d;
      pairs_q  <= pairs_d;
      addr_q   <= addr_d;
      match_q  <= match_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_a_q   <= id_a_d;
    end
  end

  assign card_addr_out  = addr_q;
  assign hidden_bus     = hidden_q;
  assign blink_bus      = blink_q;
  assign sel_bus        = sel_q;
  assign cursor_out     = cursor_q;
  assign pairs_left_out = pairs_q;
  assign match_out      = match_q;
  assign done_out       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_board_select_ctrl.sv
// ============================================================================
// tb_board_select_ctrl : directed bench with a cell/pair-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_board_select_ctrl;

  localparam int ID_W      = 4;
  localparam int MISS_HOLD = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
  logic            tick = 1'b0;
  logic [ID_W-1:0] card_id = '0;
  logic [5:0]      card_addr;
  logic [35:0]     hidden_bus, blink_bus, sel_bus;
  logic [5:0]      cursor;
  logic [4:0]      pairs_left;
  logic            match, done;

  int n_tests = 0;
  int n_fail  = 0;

  int ids [36];
  int pa  [18];
  int pb  [18];

  board_select_ctrl #(.ID_W(ID_W), .MISS_HOLD(MISS_HOLD)) dut (
    .clk100_in      (clk),
    .rst_in         (rst),
    .btn_up_in      (up),
    .btn_down_in    (down),
    .btn_left_in    (left),
    .btn_right_in   (right),
    .btn_sel_in     (sel),
    .tick100_in     (tick),
    .card_id_in     (card_id),
    .card_addr_out  (card_addr),
    .hidden_bus     (hidden_bus),
    .blink_bus      (blink_bus),
    .sel_bus        (sel_bus),
    .cursor_out     (cursor),
    .pairs_left_out (pairs_left),
    .match_out      (match),
    .done_out       (done)
  );

  always #5 clk = ~clk;

  // Card table: synchronous read, one cycle of latency
  always @(posedge clk) card_id <= ID_W'(ids[card_addr]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: cells, a pending pair, and timers ----------
  bit          m_valid = 0;
  int          m_row, m_col, m_a, m_b, m_busy, m_miss, m_pairs, m_addr;
  bit          m_done, m_match;
  bit [35:0]   m_hidden;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_row = 0; m_col = 0; m_a = -1; m_b = -1; m_busy = 0;
      m_miss = 0; m_pairs = 18; m_addr = 0; m_done = 0; m_match = 0; m_hidden = '0;
    end else if (m_valid) begin
      m_match = 0;
      if (m_done) begin
      end else if (m_busy == 3) begin
        m_busy = 2; m_addr = m_b;
      end else if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
        if (ids[m_a] == ids[m_b]) begin
          m_hidden[m_a] = 1'b1; m_hidden[m_b] = 1'b1;
          m_a = -1; m_b = -1;
          if (m_pairs > 0) m_pairs--;
          m_match = 1;
          if (m_pairs == 0) m_done = 1;
          else m_addr = m_row * 6 + m_col;
        end else begin
          m_miss = MISS_HOLD;
        end
      end else if (m_miss > 0) begin
        if (tick) begin
          m_miss--;
          if (m_miss == 0) begin
            m_a = -1; m_b = -1; m_addr = m_row * 6 + m_col;
          end
        end
      end else begin
        if (sel) begin
          if (m_a < 0) begin
            if (!m_hidden[m_row * 6 + m_col]) m_a = m_row * 6 + m_col;
          end else if (m_row * 6 + m_col == m_a) begin
            m_a = -1;
          end else if (!m_hidden[m_row * 6 + m_col]) begin
            m_b = m_row * 6 + m_col; m_busy = 3; m_addr = m_a;
          end
        end else if (up)    m_row = (m_row + 5) % 6;
        else if (down)      m_row = (m_row + 1) % 6;
        else if (left)      m_col = (m_col + 5) % 6;
        else if (right)     m_col = (m_col + 1) % 6;
        if (m_busy == 0) m_addr = m_row * 6 + m_col;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [35:0] e_blink, e_sel;
      e_blink = '0;
      e_sel   = '0;
      if (!m_done) e_blink[m_row * 6 + m_col] = 1'b1;
      if (m_a >= 0) e_sel[m_a] = 1'b1;
      if (m_b >= 0) e_sel[m_b] = 1'b1;
      chk("model_cursor", 64'(cursor),     64'(m_row * 6 + m_col));
      chk("model_blink",  64'(blink_bus),  64'(e_blink));
      chk("model_sel",    64'(sel_bus),    64'(e_sel));
      chk("model_hidden", 64'(hidden_bus), m_done ? 64'hF_FFFF_FFFF : 64'(m_hidden));
      chk("model_pairs",  64'(pairs_left), 64'(m_pairs));
      chk("model_match",  64'(match),      64'(m_match));
      chk("model_done",   64'(done),       64'(m_done));
      chk("model_addr",   64'(card_addr),  64'(m_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs set here are sampled by the next rising edge.
  task automatic cyc(input logic [4:0] btn, input logic tk);
    @(posedge clk);
    #1;
    {sel, up, down, left, right} = btn;
    tick = tk;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'b0, 1'b0);
  endtask

  task automatic move_to(input int target);
    int dr, dc;
    dr = ((target / 6) - m_row + 6) % 6;
    dc = ((target % 6) - m_col + 6) % 6;
    for (int i = 0; i < dr; i++) cyc(5'b00100, 1'b0);
    for (int i = 0; i < dc; i++) cyc(5'b00001, 1'b0);
    cyc(5'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    {sel, up, down, left, right} = '0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [4:0] B_SEL = 5'b10000, B_UP = 5'b01000, B_LEFT = 5'b00010,
                         B_RIGHT = 5'b00001;

  initial begin
    int rem [34];
    int k;
    // Pair table: (3,10) first, the remaining cells paired k with k+17
    k = 0;
    for (int c = 0; c < 36; c++) if (c != 3 && c != 10) begin rem[k] = c; k++; end
    pa[0] = 3; pb[0] = 10; ids[3] = 0; ids[10] = 0;
    for (int p = 0; p < 17; p++) begin
      pa[p + 1] = rem[p];
      pb[p + 1] = rem[p + 17];
      ids[rem[p]]      = (p + 1) % 16;
      ids[rem[p + 17]] = (p + 1) % 16;
    end

    do_reset();
    chk("reset_cursor", 64'(cursor), 64'd0);
    chk("reset_blink",  64'(blink_bus), 64'h1);
    chk("reset_pairs",  64'(pairs_left), 64'd18);
    chk("reset_hidden", 64'(hidden_bus), 64'd0);

    // Wrap-around moves
    cyc(B_LEFT, 1'b0);  idle(1);
    chk("left_wrap_cursor", 64'(cursor), 64'd5);
    chk("left_wrap_blink",  64'(blink_bus), 64'h20);
    cyc(B_UP, 1'b0);    idle(1);
    chk("up_wrap_cursor", 64'(cursor), 64'd35);
    chk("up_wrap_blink",  64'(blink_bus), 64'h8_0000_0000);
    cyc(B_RIGHT, 1'b0); idle(1);
    chk("right_wrap_cursor", 64'(cursor), 64'd30);

    // Select and deselect the same cell
    move_to(7);
    cyc(B_SEL, 1'b0); idle(1);
    chk("sel7_bus", 64'(sel_bus), 64'h80);
    cyc(B_SEL, 1'b0); idle(1);
    chk("desel7_bus", 64'(sel_bus), 64'd0);
    idle(4);

    // Matching pair 3/10
    move_to(3);
    cyc(B_SEL, 1'b0);
    move_to(10);
    cyc(B_SEL, 1'b0);
    idle(4);
    chk("match_pulse",  64'(match), 64'd1);
    chk("match_hidden", 64'(hidden_bus), 64'h408);
    chk("match_pairs",  64'(pairs_left), 64'd17);
    chk("match_sel",    64'(sel_bus), 64'd0);
    idle(1);
    chk("match_one_cycle", 64'(match), 64'd0);
    move_to(3);
    cyc(B_SEL, 1'b0); idle(1);
    chk("sel_hidden_ignored", 64'(sel_bus), 64'd0);

    // Mismatch 0/1 with buttons during FETCH_B and MISS
    move_to(0);
    cyc(B_SEL, 1'b0);
    cyc(B_RIGHT, 1'b0);
    cyc(B_SEL, 1'b0);
    cyc(5'b0, 1'b0);
    cyc(B_RIGHT, 1'b0);
    cyc(5'b0, 1'b0);
    cyc(B_RIGHT, 1'b0);
    cyc(5'b0, 1'b1);
    cyc(B_RIGHT, 1'b1);
    cyc(5'b0, 1'b0);
    chk("miss_sel_held",  64'(sel_bus), 64'h3);
    chk("miss_cursor",    64'(cursor), 64'd1);
    cyc(5'b0, 1'b1);
    idle(1);
    chk("miss_sel_clear", 64'(sel_bus), 64'd0);
    chk("miss_cursor_after", 64'(cursor), 64'd1);

    // Reset in the middle of a miss hold
    move_to(2);
    cyc(B_SEL, 1'b0);
    move_to(4);
    cyc(B_SEL, 1'b0);
    idle(4);
    cyc(5'b0, 1'b1);
    idle(1);
    chk("pre_reset_sel", 64'(sel_bus), 64'h14);
    do_reset();
    chk("rst_miss_sel",    64'(sel_bus), 64'd0);
    chk("rst_miss_cursor", 64'(cursor), 64'd0);
    chk("rst_miss_hidden", 64'(hidden_bus), 64'd0);
    chk("rst_miss_pairs",  64'(pairs_left), 64'd18);
    chk("rst_miss_addr",   64'(card_addr), 64'd0);
    cyc(5'b0, 1'b1); cyc(5'b0, 1'b1); cyc(5'b0, 1'b1); idle(1);
    chk("rst_no_resume_sel", 64'(sel_bus), 64'd0);

    // Clear the whole board
    for (int p = 0; p < 18; p++) begin
      move_to(pa[p]);
      cyc(B_SEL, 1'b0);
      move_to(pb[p]);
      cyc(B_SEL, 1'b0);
      idle(5);
    end
    chk("done_flag",   64'(done), 64'd1);
    chk("done_hidden", 64'(hidden_bus), 64'hF_FFFF_FFFF);
    chk("done_blink",  64'(blink_bus), 64'd0);
    chk("done_pairs",  64'(pairs_left), 64'd0);
    chk("done_sel",    64'(sel_bus), 64'd0);
    cyc(B_SEL, 1'b0); cyc(B_UP, 1'b0); cyc(B_LEFT, 1'b1); idle(2);
    chk("done_cursor_frozen", 64'(cursor), 64'(pb[17]));
    chk("done_held", 64'(done), 64'd1);
    chk("done_blink_held", 64'(blink_bus), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
